// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD delta applier: FSM encoding, BCD constants and sign polarity.
package bcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ONES,
        TENS,
        HUNS,
        DONE
    } state_t;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [3:0] BCD_RADIX = 4'd10;

    localparam logic SIGN_POS = 1'b0;
    localparam logic SIGN_NEG = 1'b1;

    function automatic logic digit_invalid(input logic [3:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_delta_applier_if.sv
// Request/result bundle between a requester (master) and the BCD delta applier (slave).
interface bcd_delta_applier_if;

    logic       start;
    logic [3:0] base_ones;
    logic [3:0] base_tens;
    logic [3:0] base_huns;
    logic [3:0] delta_ones;
    logic [3:0] delta_tens;
    logic [3:0] delta_huns;
    logic       sign;
    logic       busy;
    logic       done;
    logic [3:0] out_ones;
    logic [3:0] out_tens;
    logic [3:0] out_huns;
    logic       out_of_range;
    logic       bcd_err;

    modport master (
        output start, base_ones, base_tens, base_huns,
               delta_ones, delta_tens, delta_huns, sign,
        input  busy, done, out_ones, out_tens, out_huns, out_of_range, bcd_err
    );

    modport slave (
        input  start, base_ones, base_tens, base_huns,
               delta_ones, delta_tens, delta_huns, sign,
        output busy, done, out_ones, out_tens, out_huns, out_of_range, bcd_err
    );

endinterface

// File: rtl/bcd_digit_alu.sv
// One BCD digit of add or subtract with ripple carry/borrow in and out.
module bcd_digit_alu
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] digit,
    output logic       cout
);

    logic [4:0] sum;
    logic [4:0] rhs;
    logic [3:0] raw_diff;
    logic       borrow;

    // Subtraction works on the low nibble modulo 16; adding the radix back fixes a borrowed digit.
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        rhs      = {1'b0, b} + {4'b0, cin};
        raw_diff = a - b - {3'b0, cin};
        borrow   = {1'b0, a} < rhs;
        digit    = '0;
        cout     = 1'b0;
        if (sub) begin
            cout  = borrow;
            digit = borrow ? raw_diff + BCD_RADIX : raw_diff;
        end else if (sum > {1'b0, BCD_MAX}) begin
            cout  = 1'b1;
            digit = sum[3:0] - BCD_RADIX;
        end else begin
            digit = sum[3:0];
        end
    end

endmodule

// File: rtl/bcd_delta_applier.sv
// Applies a signed 3-digit BCD delta to a BCD base, one digit per clock behind a start/done handshake.
module bcd_delta_applier
    import bcd_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    bcd_delta_applier_if.slave        bus
);

    state_t     state;
    state_t     state_next;

    logic [3:0] a_ones, a_tens, a_huns;
    logic [3:0] b_ones, b_tens, b_huns;
    logic [3:0] r_ones, r_tens;
    logic       sub_r;
    logic       carry;

    logic [3:0] alu_a, alu_b, alu_digit;
    logic       alu_cout;
    logic       operand_err;

    logic [3:0] out_ones_r, out_tens_r, out_huns_r;
    logic       out_of_range_r;
    logic       bcd_err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = ONES;
            ONES:    state_next = TENS;
            TENS:    state_next = HUNS;
            HUNS:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The single digit ALU is steered onto whichever digit pair the FSM is working on.
    always_comb begin
        alu_a = a_huns;
        alu_b = b_huns;
        case (state)
            ONES: begin
                alu_a = a_ones;
                alu_b = b_ones;
            end
            TENS: begin
                alu_a = a_tens;
                alu_b = b_tens;
            end
            default: ;
        endcase
    end

    bcd_digit_alu u_alu (
        .a     (alu_a),
        .b     (alu_b),
        .cin   (carry),
        .sub   (sub_r),
        .digit (alu_digit),
        .cout  (alu_cout)
    );

    assign operand_err = digit_invalid(a_ones) | digit_invalid(a_tens) | digit_invalid(a_huns)
                       | digit_invalid(b_ones) | digit_invalid(b_tens) | digit_invalid(b_huns);

    // Visible outputs change only on the edge into DONE, so the old result stays up while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ones         <= '0;
            a_tens         <= '0;
            a_huns         <= '0;
            b_ones         <= '0;
            b_tens         <= '0;
            b_huns         <= '0;
            r_ones         <= '0;
            r_tens         <= '0;
            sub_r          <= 1'b0;
            carry          <= 1'b0;
            out_ones_r     <= '0;
            out_tens_r     <= '0;
            out_huns_r     <= '0;
            out_of_range_r <= 1'b0;
            bcd_err_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_ones <= bus.base_ones;
                        a_tens <= bus.base_tens;
                        a_huns <= bus.base_huns;
                        b_ones <= bus.delta_ones;
                        b_tens <= bus.delta_tens;
                        b_huns <= bus.delta_huns;
                        sub_r  <= (bus.sign == SIGN_NEG);
                        carry  <= 1'b0;
                    end
                end
                ONES: begin
                    r_ones <= alu_digit;
                    carry  <= alu_cout;
                end
                TENS: begin
                    r_tens <= alu_digit;
                    carry  <= alu_cout;
                end
                HUNS: begin
                    carry          <= alu_cout;
                    out_ones_r     <= r_ones;
                    out_tens_r     <= r_tens;
                    out_huns_r     <= alu_digit;
                    out_of_range_r <= alu_cout;
                    bcd_err_r      <= operand_err;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.out_ones     = out_ones_r;
    assign bus.out_tens     = out_tens_r;
    assign bus.out_huns     = out_huns_r;
    assign bus.out_of_range = out_of_range_r;
    assign bus.bcd_err      = bcd_err_r;

endmodule

// File: tb/tb_bcd_delta_applier.sv
// Directed bench for bcd_delta_applier: expected results queue at capture and are checked on done.
module tb_bcd_delta_applier;

    typedef struct {
        logic [11:0] val;
        logic        oor;
        logic        err;
        bit          chk_digits;
        int          cap;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_count = 0;
    int   dc0;
    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_delta_applier_if bus ();

    bcd_delta_applier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int bcd_to_int(input logic [11:0] v);
        return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic exp_t model(input logic [11:0] base, input logic [11:0] delta,
                                   input logic s, input bit chk, input int cap);
        exp_t e;
        int   v;
        v = s ? bcd_to_int(base) - bcd_to_int(delta) : bcd_to_int(base) + bcd_to_int(delta);
        e.oor = (v < 0) || (v > 999);
        v = (v + 1000) % 1000;
        e.val = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        e.err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (base[i*4 +: 4] > 4'd9 || delta[i*4 +: 4] > 4'd9) e.err = 1'b1;
        end
        e.chk_digits = chk;
        e.cap = cap;
        return e;
    endfunction

    task automatic driveOperands(input logic [11:0] base, input logic [11:0] delta, input logic s);
        bus.base_huns  = base[11:8];
        bus.base_tens  = base[7:4];
        bus.base_ones  = base[3:0];
        bus.delta_huns = delta[11:8];
        bus.delta_tens = delta[7:4];
        bus.delta_ones = delta[3:0];
        bus.sign       = s;
    endtask

    // Called just after a falling edge; returns 1 time unit after the capture edge.
    task automatic applyStimulus(input logic [11:0] base, input logic [11:0] delta,
                                 input logic s, input bit chk);
        driveOperands(base, delta, s);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(base, delta, s, chk, cyc));
        bus.start = 1'b0;
    endtask

    task automatic waitIdle();
        int budget;
        budget = 20;
        do begin
            @(negedge clk);
            #1;
            budget--;
        end while ((sb.size() != 0 || bus.busy !== 1'b0) && budget > 0);
        if (budget == 0) checkOutput("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.done === 1'b1) begin
            done_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("latency", 32'(cyc - e.cap), 32'd3);
                checkOutput("busy_with_done", {31'd0, bus.busy}, 32'd1);
                if (e.chk_digits)
                    checkOutput("result", {20'd0, bus.out_huns, bus.out_tens, bus.out_ones}, {20'd0, e.val});
                checkOutput("out_of_range", {31'd0, bus.out_of_range}, {31'd0, e.oor});
                checkOutput("bcd_err", {31'd0, bus.bcd_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        bus.start = 1'b0;
        driveOperands(12'h000, 12'h000, 1'b0);
        #12;
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset_out", {20'd0, bus.out_huns, bus.out_tens, bus.out_ones}, 32'h000);
        checkOutput("reset_flags", {30'd0, bus.out_of_range, bus.bcd_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(12'h123, 12'h456, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(12'h199, 12'h001, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(12'h999, 12'h001, 1'b0, 1'b1);
        waitIdle();
        applyStimulus(12'h500, 12'h001, 1'b1, 1'b1);
        waitIdle();
        applyStimulus(12'h005, 12'h007, 1'b1, 1'b1);
        waitIdle();

        // Stray start pulses in TENS and DONE; previous result 998 must stay up until E3.
        dc0 = done_count;
        applyStimulus(12'h321, 12'h111, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("hold_in_tens", {20'd0, bus.out_huns, bus.out_tens, bus.out_ones}, 32'h998);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("hold_in_huns", {20'd0, bus.out_huns, bus.out_tens, bus.out_ones}, 32'h998);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("single_done", 32'(done_count - dc0), 32'd1);
        checkOutput("idle_after_ignored", {31'd0, bus.busy}, 32'd0);

        // Start held high: second capture at E5; operands swapped right after E0.
        driveOperands(12'h250, 12'h250, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(12'h250, 12'h250, 1'b0, 1'b1, cyc));
        driveOperands(12'h100, 12'h050, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        sb.push_back(model(12'h100, 12'h050, 1'b1, 1'b1, cyc));
        @(negedge clk);
        bus.start = 1'b0;
        waitIdle();

        @(negedge clk);
        applyStimulus(12'h1C3, 12'h001, 1'b0, 1'b0);
        waitIdle();

        // Reset while in HUNS abandons the operation without a done pulse.
        applyStimulus(12'h222, 12'h111, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
        checkOutput("rst_out", {20'd0, bus.out_huns, bus.out_tens, bus.out_ones}, 32'h000);
        checkOutput("rst_flags", {30'd0, bus.out_of_range, bus.bcd_err}, 32'd0);
        while (sb.size() != 0) e = sb.pop_front();
        dc0 = done_count;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("no_done_after_rst", 32'(done_count - dc0), 32'd0);
        @(negedge clk);
        applyStimulus(12'h010, 12'h010, 1'b1, 1'b1);
        waitIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_delta_applier.md
# bcd_delta_applier

Sequential 3-digit BCD add/subtract unit that applies a signed BCD change (magnitude + sign) to a stored BCD base value. It is the inverse of the team's combinational BCD difference path: that path turns two values into |x−y| plus a sign, and this block turns a base value plus a signed delta back into a value. It processes one decimal digit per clock (ones, then tens, then hundreds) with a ripple carry/borrow, behind a start/done handshake. It feeds the 7-segment display path and any counter logic that accumulates signed changes.

## Interface
Parameters:
- none (width fixed at 3 BCD digits)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- base_ones / base_tens / base_huns  in  4 each  base value, BCD digits
- delta_ones / delta_tens / delta_huns  in  4 each  delta magnitude, BCD digits
- sign  in  1  0 = add delta, 1 = subtract delta; same polarity as the difference path's sign
- busy  out  1  high in states ONES, TENS, HUNS, DONE
- done  out  1  one-cycle pulse; result and flags valid
- out_ones / out_tens / out_huns  out  4 each  result digits; held between operations
- out_of_range  out  1  true result >999 or <0; valid with done, then held
- bcd_err  out  1  some captured operand digit >9; valid with done, then held

## Operation
- FSM states: IDLE → ONES → TENS → HUNS → DONE → IDLE. No other transitions except reset.
- IDLE with start=1: capture all 6 operand digits and sign into working registers, clear carry/borrow, go to ONES. IDLE with start=0: stay.
- ONES/TENS/HUNS: compute one digit from the captured digits and the current carry, store the digit and carry-out, advance.
- Add, per digit: s = a + b + cin (5 bits). If s > 9: digit = s − 10, cout = 1. Otherwise digit = s, cout = 0.
- Subtract, per digit: d = a − b − bin. If negative: digit = d + 10, bout = 1. Otherwise digit = d, bout = 0.
- Results wrap modulo 1000, e.g. 999+1 = 000 and 005−007 = 998. out_of_range = final carry/borrow out of the hundreds digit.
- bcd_err: OR of (digit > 9) over all six captured operand digits.
  - Invalid digits are still processed by the formulas above; out_* contents are then unspecified.
  - bcd_err is the only guaranteed indication.
- Output update: out_*, out_of_range and bcd_err are written only on the edge entering DONE. The previous result stays visible while busy.
- start is ignored in ONES, TENS, HUNS and DONE. It is not queued; the requester must re-assert it in IDLE.
- Operand inputs may change after the capture edge without affecting the operation in flight.

## Timing
- Capture edge E0 (IDLE, start=1).
- E1, E2, E3 compute ones, tens, hundreds. E3 also loads the outputs and enters DONE.
- done=1 and busy=1 for exactly one cycle, between E3 and E4. E4 returns to IDLE; busy=0 from E4.
- Latency: done rises 3 cycles after the capture edge.
- Minimum start-to-start spacing is 5 cycles.
- Back-to-back: start held high continuously is accepted again at E5.
- Reset values (asynchronous, immediate):
  - state IDLE; busy=0, done=0;
  - out_ones, out_tens, out_huns = 0; out_of_range=0, bcd_err=0;
  - working registers and carry = 0.
- Reset mid-operation: the operation is abandoned. No done pulse, outputs read 000. The first start after rst deasserts is accepted normally.

## Structure
- Shared package bcd_pkg:
  - FSM state encoding (IDLE, ONES, TENS, HUNS, DONE);
  - BCD_MAX = 9, BCD_RADIX = 10;
  - SIGN_POS = 0, SIGN_NEG = 1.
- One combinational sub-module, bcd_digit_alu: inputs a, b (4-bit), cin, sub; outputs digit (4-bit), cout. It is instantiated once and muxed by state onto the current digit pair.
- Top level holds the FSM, operand/working registers, the carry flop and the output registers.

## Test plan
- Add: base 123, delta 456, sign 0, start → done exactly 3 cycles after the capture edge; out = 579, out_of_range=0, bcd_err=0.
- Carry chain: 199 + 001 → 200. Overflow: 999 + 001 → out 000, out_of_range=1.
- Subtract with borrow: 500 − 001, sign 1 → 499. Underflow: 005 − 007 → out 998, out_of_range=1.
- Handshake:
  - start pulsed during TENS and during DONE → ignored, exactly one done pulse;
  - start held high → second capture at E5;
  - out_* hold the old result until E3.
- Invalid input: base_tens = 4'hC, others valid → bcd_err=1 with done.
- Reset: assert rst during HUNS → busy, done and outputs go to 0 immediately, no done pulse. Then 010 − 010 → 000, out_of_range=0.
